// File: rtl/sub_serial.sv
// Digit-serial two's-complement subtractor: result = A - B (mod 2^WIDTH), computed as
// A + ~B + 1 one DIGIT-wide slice per clock with a registered carry between slices.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   start  - request; sampled only in IDLE or DONE
//   A, B   - minuend / subtrahend, captured on the accepted start edge
//   busy   - high while digits are being processed
//   done   - one-cycle pulse when the published outputs become valid
//   result - A - B mod 2^WIDTH
//   Bout   - unsigned borrow (A < B unsigned)
//   zero   - result == 0
//   neg    - result MSB
//   ovf    - signed overflow of the subtraction
module sub_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] part_q, part_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [DIGIT:0]   sum;
  logic             accept;
  logic             last;
  int unsigned      base;

  // Control: next state and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        if (cnt_q == LastCnt) begin
          last    = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // One digit slice of A + ~B + carry; the slice result is merged into the partial result so
  // the final digit can be published in the same edge it is computed.
  always_comb begin
    base   = DIGIT * 32'(cnt_q);
    sum    = {1'b0, a_q[base +: DIGIT]} + {1'b0, ~b_q[base +: DIGIT]}
             + {{DIGIT{1'b0}}, carry_q};
    part_d = part_q;
    part_d[base +: DIGIT] = sum[DIGIT-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      result  <= '0;
      Bout    <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= B;
      cnt_q   <= '0;
      carry_q <= 1'b1;  // +1 of the two's-complement negation of B
    end else if (busy) begin
      part_q  <= part_d;
      carry_q <= sum[DIGIT];
      cnt_q   <= cnt_q + 1'b1;
      if (last) begin
        result <= part_d;
        Bout   <= ~sum[DIGIT];
        zero   <= ~|part_d;
        neg    <= part_d[WIDTH-1];
        ovf    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (part_d[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: a transaction-level model (operands, a run countdown and
// plain integer subtraction) is compared against the DUT on every falling edge, and directed
// cases pin the model with hand-computed literals.
module tb_sub_serial;

  localparam int W = 32;
  localparam int D = 4;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, bout, zero, neg, ovf;
  logic [W-1:0] result;

  sub_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .result(result),
    .Bout  (bout),
    .zero  (zero),
    .neg   (neg),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic         m_run, m_done;
  int           m_left;
  logic [W-1:0] m_a, m_b;
  logic [W-1:0] e_res;
  logic         e_bout, e_zero, e_neg, e_ovf;
  longint       m_sdiff;
  logic [W-1:0] m_diff;

  assign m_diff  = m_a - m_b;
  assign m_sdiff = longint'($signed(m_a)) - longint'($signed(m_b));

  always @(posedge clk) begin
    if (rst) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_a    <= '0;
      m_b    <= '0;
      e_res  <= '0;
      e_bout <= 1'b0;
      e_zero <= 1'b0;
      e_neg  <= 1'b0;
      e_ovf  <= 1'b0;
    end else if (m_run) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
        e_res  <= m_diff;
        e_bout <= (m_a < m_b);
        e_zero <= (m_a == m_b);
        e_neg  <= m_diff[W-1];
        e_ovf  <= (m_sdiff > 64'sd2147483647) || (m_sdiff < -64'sd2147483648);
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_a    <= a;
        m_b    <= b;
        m_run  <= 1'b1;
        m_left <= N;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("result", result, e_res);
      chk("Bout", bout, e_bout);
      chk("zero", zero, e_zero);
      chk("neg", neg, e_neg);
      chk("ovf", ovf, e_ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents operands with start for one edge; returns one falling edge after acceptance.
  task automatic go(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!done && c < 30) begin
      tick(1);
      c++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles expected %0d", c, N + 1);
    end
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] er,
                    input logic eb, input logic ez, input logic en, input logic eo);
    int c;
    go(x, y);
    wait_done(1, c);
    chk("lit_latency", 64'(c), 64'(N + 1));
    chk("lit_result", result, er);
    chk("lit_bout", bout, eb);
    chk("lit_zero", zero, ez);
    chk("lit_neg", neg, en);
    chk("lit_ovf", ovf, eo);
    tick(1);
  endtask

  initial begin
    int c;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick(2);
    chk_en = 1'b1;
    chk("lit_reset_busy", busy, 1'b0);
    chk("lit_reset_result", result, 32'h0);
    rst = 1'b0;
    tick(1);

    op(32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    op(32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0);
    op(32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    op(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1);

    // start held high with operands changing during RUN
    a = 32'd100;
    b = 32'd58;
    start = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      b = $urandom;
      tick(1);
    end
    start = 1'b0;
    wait_done(6, c);
    chk("lit_held_latency", 64'(c), 64'(N + 1));
    chk("lit_held_result", result, 32'd42);
    tick(1);
    chk("lit_held_single_done", done, 1'b0);
    tick(3);

    // back-to-back: new start in the DONE cycle
    go(32'd20, 32'd7);
    wait_done(1, c);
    chk("lit_b2b_first", result, 32'd13);
    a = 32'd10;
    b = 32'd4;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("lit_b2b_busy", busy, 1'b1);
    chk("lit_b2b_hold", result, 32'd13);
    wait_done(1, c);
    chk("lit_b2b_latency", 64'(c), 64'(N + 1));
    chk("lit_b2b_second", result, 32'd6);
    tick(1);

    // reset in the middle of RUN
    go(32'd1000, 32'd1);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("lit_abort_busy", busy, 1'b0);
    chk("lit_abort_result", result, 32'h0);
    tick(14);
    op(32'd9, 32'd9, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // random traffic: start, operands and occasional reset vary each cycle
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      b   = ($urandom_range(0, 7) == 0) ? a : $urandom;
      rst = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
